// File: rtl/model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_pkg.sv
// Shared widths, saturation bounds, iteration count and FSM encoding for the
// sequential 24s/16s signed divider.
package model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_pkg;

   localparam int DIN0_W = 24;
   localparam int DIN1_W = 16;
   localparam int DOUT_W = 11;
   localparam int REM_W  = 16;
   localparam int PREM_W = DIN1_W + 1;
   localparam int ITERS  = 24;
   localparam int CNT_W  = 5;

   // Saturation bounds expressed as magnitudes so they compare against |q|.
   localparam int Q_MAX_MAG = 1023;
   localparam int Q_MIN_MAG = 1024;
   localparam logic [DOUT_W-1:0] Q_MAX = 11'h3FF;
   localparam logic [DOUT_W-1:0] Q_MIN = 11'h400;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_core.sv
// FSM and restoring shift-subtract datapath of the signed divider; works on
// magnitudes and applies signs and saturation once at the end.
module model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_core
   import model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              start,
   input  logic [DIN0_W-1:0] din0,
   input  logic [DIN1_W-1:0] din1,
   output logic              busy,
   output logic              done,
   output logic [DOUT_W-1:0] dout,
   output logic [REM_W-1:0]  rem,
   output logic              ovf,
   output logic              dbz
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DIN0_W-1:0]   quo_q, quo_d;
   logic [DIN1_W-1:0]   dvs_q, dvs_d;
   logic [PREM_W-1:0]   prem_q, prem_d;
   logic                sign_a_q, sign_a_d;
   logic                sign_b_q, sign_b_d;
   logic                zero_q, zero_d;
   logic [DOUT_W-1:0]   res_q, res_d;
   logic [REM_W-1:0]    rres_q, rres_d;
   logic                rovf_q, rovf_d;
   logic [DOUT_W-1:0]   dout_q, dout_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic                ovf_q, ovf_d;
   logic                dbz_q, dbz_d;
   logic                done_q, done_d;

   logic [PREM_W-1:0]   prem_shift;
   logic [PREM_W-1:0]   prem_diff;
   logic                fits;

   // quo_q starts as the dividend magnitude; its MSB feeds the partial
   // remainder while quotient bits enter at the LSB.
   assign prem_shift = {prem_q[PREM_W-2:0], quo_q[DIN0_W-1]};
   assign prem_diff  = prem_shift - {1'b0, dvs_q};
   assign fits       = (prem_shift >= {1'b0, dvs_q});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      prem_d   = prem_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      zero_d   = zero_q;
      res_d    = res_q;
      rres_d   = rres_q;
      rovf_d   = rovf_q;
      dout_d   = dout_q;
      rem_d    = rem_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;
      done_d   = done_q;
      if (ce) begin
         done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  quo_d    = din0[DIN0_W-1] ? -din0 : din0;
                  dvs_d    = din1[DIN1_W-1] ? -din1 : din1;
                  sign_a_d = din0[DIN0_W-1];
                  sign_b_d = din1[DIN1_W-1];
                  zero_d   = (din1 == '0);
                  prem_d   = '0;
                  cnt_d    = CNT_W'(ITERS - 1);
                  state_d  = ST_CALC;
               end
            end
            ST_CALC: begin
               prem_d = fits ? prem_diff : prem_shift;
               quo_d  = {quo_q[DIN0_W-2:0], fits};
               if (cnt_q == '0) state_d = ST_FIX;
               else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FIX: begin
               rovf_d = 1'b0;
               rres_d = sign_a_q ? -prem_q[REM_W-1:0] : prem_q[REM_W-1:0];
               if (zero_q) begin
                  res_d  = sign_a_q ? Q_MIN : Q_MAX;
                  rres_d = '0;
               end else if (sign_a_q != sign_b_q) begin
                  if (quo_q > DIN0_W'(Q_MIN_MAG)) begin
                     res_d  = Q_MIN;
                     rovf_d = 1'b1;
                  end else begin
                     res_d = -quo_q[DOUT_W-1:0];
                  end
               end else if (quo_q > DIN0_W'(Q_MAX_MAG)) begin
                  res_d  = Q_MAX;
                  rovf_d = 1'b1;
               end else begin
                  res_d = quo_q[DOUT_W-1:0];
               end
               state_d = ST_DONE;
            end
            ST_DONE: begin
               dout_d  = res_q;
               rem_d   = rres_q;
               ovf_d   = rovf_q;
               dbz_d   = zero_q;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         prem_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         zero_q   <= 1'b0;
         res_q    <= '0;
         rres_q   <= '0;
         rovf_q   <= 1'b0;
         dout_q   <= '0;
         rem_q    <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         prem_q   <= prem_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         zero_q   <= zero_d;
         res_q    <= res_d;
         rres_q   <= rres_d;
         rovf_q   <= rovf_d;
         dout_q   <= dout_d;
         rem_q    <= rem_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign dout = dout_q;
   assign rem  = rem_q;
   assign ovf  = ovf_q;
   assign dbz  = dbz_q;

endmodule

// File: rtl/model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq.sv
// Parameterised wrapper for the sequential signed divider; only the default
// widths are supported, anything else is rejected at elaboration.
module model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq
   import model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_pkg::*;
#(
   parameter int ID         = 32'd1,
   parameter int NUM_STAGE  = 32'd26,
   parameter int din0_WIDTH = 24,
   parameter int din1_WIDTH = 16,
   parameter int dout_WIDTH = 11,
   parameter int rem_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [rem_WIDTH-1:0]  rem,
   output logic                  ovf,
   output logic                  dbz
);

   if (din0_WIDTH != DIN0_W || din1_WIDTH != DIN1_W || dout_WIDTH != DOUT_W ||
       rem_WIDTH != REM_W || NUM_STAGE != ITERS + 2 || ID < 0) begin : g_bad_param
      $error("unsupported parameter set for sdiv_24s_16s_11_seq");
   end

   model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq_core u_core (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .start (start),
      .din0  (din0),
      .din1  (din1),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .rem   (rem),
      .ovf   (ovf),
      .dbz   (dbz)
   );

endmodule

// File: tb/tb_model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq.sv
// Directed self-checking bench for the sequential signed divider: results,
// latency, clock-enable freeze, reset abort and back-to-back starts.
module tb_model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq;

   logic        clk;
   logic        reset;
   logic        ce;
   logic        start;
   logic [23:0] din0;
   logic [15:0] din1;
   logic        busy;
   logic        done;
   logic [10:0] dout;
   logic [15:0] rem;
   logic        ovf;
   logic        dbz;

   int checks = 0;
   int errors = 0;
   int cycles;
   int done_seen;

   model_nexys_hls4ml_prj_1_sdiv_24s_16s_11_seq dut (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .start (start),
      .din0  (din0),
      .din1  (din1),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .rem   (rem),
      .ovf   (ovf),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
         $error("[TB] %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is seen by the following posedge (edge 0).
   task automatic applyStimulus(input int a, input int b);
      din0  = 24'(a);
      din1  = 16'(b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int from, output int n);
      n = from;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic checkResult(input string tag, input int q, input int r,
                              input int o, input int z);
      checkOutput({tag, ".done"}, int'(done), 1);
      checkOutput({tag, ".dout"}, int'($signed(dout)), q);
      checkOutput({tag, ".rem"},  int'($signed(rem)), r);
      checkOutput({tag, ".ovf"},  int'(ovf), o);
      checkOutput({tag, ".dbz"},  int'(dbz), z);
   endtask

   task automatic runDiv(input string tag, input int a, input int b,
                         input int q, input int r, input int o, input int z);
      int n;
      applyStimulus(a, b);
      checkOutput({tag, ".busy"}, int'(busy), 1);
      waitDone(0, n);
      checkOutput({tag, ".latency"}, n, 26);
      checkResult(tag, q, r, o, z);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".busy"}, int'(busy), 0);
      checkOutput({tag, ".done"}, int'(done), 0);
      checkOutput({tag, ".dout"}, int'(dout), 0);
      checkOutput({tag, ".rem"},  int'(rem), 0);
      checkOutput({tag, ".ovf"},  int'(ovf), 0);
      checkOutput({tag, ".dbz"},  int'(dbz), 0);
   endtask

   initial begin
      reset = 1'b1;
      ce    = 1'b1;
      start = 1'b0;
      din0  = '0;
      din1  = '0;
      repeat (3) @(negedge clk);
      checkReset("por");

      // Start on the very first cycle reset is low.
      reset = 1'b0;
      runDiv("p1000_7", 1000, 7, 142, 6, 0, 0);
      @(negedge clk);
      checkOutput("done_pulse", int'(done), 0);
      checkOutput("dout_hold", int'($signed(dout)), 142);

      runDiv("n1000_7", -1000, 7, -142, -6, 0, 0);
      // Back-to-back: accepted on the cycle right after DONE.
      runDiv("p1000_n7", 1000, -7, -142, 6, 0, 0);
      @(negedge clk);
      runDiv("sat_pos", 5000000, 3, 1023, 2, 1, 0);
      @(negedge clk);
      runDiv("min_div_m1", -8388608, -1, 1023, 0, 1, 0);
      @(negedge clk);
      runDiv("min_div_min", -8388608, -32768, 256, 0, 0, 0);
      @(negedge clk);
      runDiv("p1024_1", 1024, 1, 1023, 0, 1, 0);
      @(negedge clk);
      runDiv("n1024_1", -1024, 1, -1024, 0, 0, 0);
      @(negedge clk);
      runDiv("n1025_1", -1025, 1, -1024, 0, 1, 0);
      @(negedge clk);
      runDiv("n7_1000", -7, 1000, 0, -7, 0, 0);
      @(negedge clk);
      runDiv("dbz_pos", 8, 0, 1023, 0, 0, 1);
      @(negedge clk);
      runDiv("dbz_neg", -8, 0, -1024, 0, 0, 1);
      @(negedge clk);

      // Freeze five cycles mid-CALC, with a stray start while busy.
      applyStimulus(1000, 7);
      repeat (9) @(negedge clk);
      ce    = 1'b0;
      din0  = 24'(5);
      din1  = 16'(1);
      start = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("freeze.busy", int'(busy), 1);
      checkOutput("freeze.done", int'(done), 0);
      ce = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(15, cycles);
      checkOutput("freeze.latency", cycles, 31);
      checkResult("freeze", 142, 6, 0, 0);
      @(negedge clk);

      // Reset at edge 10 of a division abandons it.
      applyStimulus(5000000, 3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkReset("mid_reset");
      reset = 1'b0;
      done_seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      checkOutput("mid_reset.no_done", done_seen, 0);
      checkOutput("mid_reset.dout_hold", int'(dout), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
